// File: rtl/ext_mem_arbiter.sv
// Two-requester arbiter for a memory with one read port and one write port.
// Each port is arbitrated independently; requester 1 is protected from starvation per port.
module ext_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 20,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  r0_valid,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ready,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_valid,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ready,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_qout,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_write_en
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]       rtag_q, rtag_d;

    logic r0_rd, r1_rd, r0_wr, r1_wr;
    logic wr_gnt0, wr_gnt1;
    logic rd_win0, rd_win1;
    logic rd_gnt0, rd_gnt1;
    logic hazard;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    // Port arbitration: requester 0 wins conflicts unless that port's starve counter is full.
    always_comb begin
        r0_rd   = r0_valid & ~r0_we;
        r1_rd   = r1_valid & ~r1_we;
        r0_wr   = r0_valid &  r0_we;
        r1_wr   = r1_valid &  r1_we;
        wr_gnt0 = 1'b0;
        wr_gnt1 = 1'b0;
        rd_win0 = 1'b0;
        rd_win1 = 1'b0;
        if (!rst_in) begin
            if (r0_wr && r1_wr) begin
                if (wr_cnt_q == CNT_MAX) wr_gnt1 = 1'b1;
                else                     wr_gnt0 = 1'b1;
            end else begin
                wr_gnt0 = r0_wr;
                wr_gnt1 = r1_wr;
            end
            if (r0_rd && r1_rd) begin
                if (rd_cnt_q == CNT_MAX) rd_win1 = 1'b1;
                else                     rd_win0 = 1'b1;
            end else begin
                rd_win0 = r0_rd;
                rd_win1 = r1_rd;
            end
        end
        wr_addr = wr_gnt1 ? r1_addr : r0_addr;
        rd_addr = rd_win1 ? r1_addr : r0_addr;
        // A read colliding with the granted write waits a cycle so it returns the new data.
        hazard  = (wr_gnt0 | wr_gnt1) & (rd_win0 | rd_win1) & (rd_addr == wr_addr);
        rd_gnt0 = rd_win0 & ~hazard;
        rd_gnt1 = rd_win1 & ~hazard;
    end

    always_comb begin
        r0_ready       = rd_gnt0 | wr_gnt0;
        r1_ready       = rd_gnt1 | wr_gnt1;
        mem_write_en   = wr_gnt0 | wr_gnt1;
        mem_write_addr = mem_write_en ? wr_addr : '0;
        mem_din        = wr_gnt1 ? r1_wdata : (wr_gnt0 ? r0_wdata : '0);
        mem_read_addr  = (rd_gnt0 | rd_gnt1) ? rd_addr : '0;
        r0_rvalid      = rtag_q[0] & ~rst_in;
        r1_rvalid      = rtag_q[1] & ~rst_in;
        r0_rdata       = mem_qout;
        r1_rdata       = mem_qout;
    end

    // Starve counters count conflicts lost by requester 1; a full counter hands it the next win.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (!r1_valid || wr_gnt1) begin
            wr_cnt_d = '0;
        end else if (r0_wr && r1_wr && (wr_cnt_q != CNT_MAX)) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
        if (!r1_valid || rd_gnt1) begin
            rd_cnt_d = '0;
        end else if (r0_rd && r1_rd && (rd_cnt_q != CNT_MAX)) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        rtag_d = {rd_gnt1, rd_gnt0};
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            rtag_q   <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            rtag_q   <= rtag_d;
        end
    end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Bench for ext_mem_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_ext_mem_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 32;
    localparam int          LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          r0_valid, r0_we, r1_valid, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_ready, r0_rvalid, r1_ready, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic [AW-1:0] mem_read_addr, mem_write_addr;
    logic [DW-1:0] mem_qout, mem_din;
    logic          mem_write_en;

    int checks = 0;
    int errors = 0;

    ext_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_in(rst_in),
        .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_read_addr(mem_read_addr), .mem_qout(mem_qout),
        .mem_write_addr(mem_write_addr), .mem_din(mem_din), .mem_write_en(mem_write_en)
    );

    always #5 clk = ~clk;

    // External memory: synchronous read, write at the strobed edge; preloaded on the first edge.
    logic [DW-1:0] mem [256];
    logic          mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem_loaded <= 1'b1;
        end else if (mem_write_en) begin
            mem[mem_write_addr[7:0]] <= mem_din;
        end
        mem_qout <= mem[mem_read_addr[7:0]];
    end

    // Behavioural model state.
    logic [DW-1:0] shadow [256];
    bit            model_on = 1'b0;
    int            m_tag = -1;
    logic [DW-1:0] m_rdata = '0;
    int            m_wr_starve = 0;
    int            m_rd_starve = 0;

    initial for (int i = 0; i < 256; i++) shadow[i] = 32'hA000_0000 + 32'(i);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int n);
        return (n == 1) ? r1_addr : r0_addr;
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int n);
        return (n == 1) ? r1_wdata : r0_wdata;
    endfunction

    // Who gets each port this cycle (-1 = nobody), from the rules and current inputs.
    function automatic void arb(output int rw, output int ww);
        bit wr0, wr1, rd0, rd1;
        rw = -1;
        ww = -1;
        if (rst_in) return;
        wr0 = r0_valid && r0_we;
        wr1 = r1_valid && r1_we;
        rd0 = r0_valid && !r0_we;
        rd1 = r1_valid && !r1_we;
        if (wr0 && wr1)  ww = (m_wr_starve == LIMIT) ? 1 : 0;
        else if (wr0)    ww = 0;
        else if (wr1)    ww = 1;
        if (rd0 && rd1)  rw = (m_rd_starve == LIMIT) ? 1 : 0;
        else if (rd0)    rw = 0;
        else if (rd1)    rw = 1;
        if (rw >= 0 && ww >= 0 && addr_of(rw) == addr_of(ww)) rw = -1;
    endfunction

    function automatic int next_starve(input int s, input bit conflict, input bit r1_won);
        if (!r1_valid || r1_won) return 0;
        if (conflict) return (s + 1 > LIMIT) ? LIMIT : s + 1;
        return s;
    endfunction

    always @(posedge clk) begin
        int rw, ww;
        logic [AW-1:0] a;
        if (rst_in) begin
            model_on    = 1'b1;
            m_tag       = -1;
            m_wr_starve = 0;
            m_rd_starve = 0;
        end else begin
            arb(rw, ww);
            m_tag = rw;
            if (rw >= 0) begin
                a = addr_of(rw);
                m_rdata = shadow[a[7:0]];
            end
            if (ww >= 0) begin
                a = addr_of(ww);
                shadow[a[7:0]] = wdata_of(ww);
            end
            m_wr_starve = next_starve(m_wr_starve, r0_valid && r0_we && r1_valid && r1_we, ww == 1);
            m_rd_starve = next_starve(m_rd_starve, r0_valid && !r0_we && r1_valid && !r1_we, rw == 1);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        int rw, ww;
        if (model_on) begin
            arb(rw, ww);
            check("r0_ready", 64'(r0_ready), 64'(rw == 0 || ww == 0));
            check("r1_ready", 64'(r1_ready), 64'(rw == 1 || ww == 1));
            check("mem_read_addr", 64'(mem_read_addr), (rw >= 0) ? 64'(addr_of(rw)) : 64'(0));
            check("mem_write_en", 64'(mem_write_en), 64'(ww >= 0));
            check("mem_write_addr", 64'(mem_write_addr), (ww >= 0) ? 64'(addr_of(ww)) : 64'(0));
            check("mem_din", 64'(mem_din), (ww >= 0) ? 64'(wdata_of(ww)) : 64'(0));
            check("r0_rvalid", 64'(r0_rvalid), 64'(!rst_in && m_tag == 0));
            check("r1_rvalid", 64'(r1_rvalid), 64'(!rst_in && m_tag == 1));
            if (!rst_in && m_tag >= 0) begin
                check("r0_rdata", 64'(r0_rdata), 64'(m_rdata));
                check("r1_rdata", 64'(r1_rdata), 64'(m_rdata));
            end
        end
    end

    task automatic drive(input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] pat;
        rst_in = 1'b1;
        idle();
        repeat (3) step();

        // Requests present during reset must not be granted.
        drive(1, 1, 20'h3, 32'h77, 1, 0, 20'h4, '0);
        @(negedge clk);
        check("rst_r0_ready", 64'(r0_ready), 64'(0));
        check("rst_r1_ready", 64'(r1_ready), 64'(0));
        check("rst_mem_write_en", 64'(mem_write_en), 64'(0));
        check("rst_mem_read_addr", 64'(mem_read_addr), 64'(0));
        check("rst_mem_din", 64'(mem_din), 64'(0));
        step();
        rst_in = 1'b0;

        // Read and write of different requesters in the same cycle.
        drive(1, 0, 20'h10, '0, 1, 1, 20'h20, 32'hAB);
        @(negedge clk);
        check("dual_r0_ready", 64'(r0_ready), 64'(1));
        check("dual_r1_ready", 64'(r1_ready), 64'(1));
        check("dual_read_addr", 64'(mem_read_addr), 64'h10);
        check("dual_write_en", 64'(mem_write_en), 64'(1));
        check("dual_write_addr", 64'(mem_write_addr), 64'h20);
        check("dual_din", 64'(mem_din), 64'hAB);
        step();
        idle();
        @(negedge clk);
        check("dual_r0_rvalid", 64'(r0_rvalid), 64'(1));
        check("dual_r0_rdata", 64'(r0_rdata), 64'hA000_0010);
        check("dual_r1_rvalid", 64'(r1_rvalid), 64'(0));
        step();

        // Continuous read conflict: r1 wins every fifth cycle.
        drive(1, 0, 20'h1, '0, 1, 0, 20'h2, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[i] = r1_ready;
            step();
        end
        check("starve_pattern", 64'(pat), 64'(10'b10000_10000));
        idle();
        step();

        // Write/read to the same address: read stalls, then returns the new data.
        drive(1, 1, 20'h33, 32'h5555, 1, 0, 20'h33, '0);
        @(negedge clk);
        check("hazard_r0_ready", 64'(r0_ready), 64'(1));
        check("hazard_r1_ready", 64'(r1_ready), 64'(0));
        step();
        drive(0, 0, '0, '0, 1, 0, 20'h33, '0);
        @(negedge clk);
        check("hazard_retry_ready", 64'(r1_ready), 64'(1));
        check("hazard_retry_addr", 64'(mem_read_addr), 64'h33);
        step();
        idle();
        @(negedge clk);
        check("hazard_rvalid", 64'(r1_rvalid), 64'(1));
        check("hazard_rdata", 64'(r1_rdata), 64'h5555);
        step();

        // Fill the write starve counter, accept an r1 read, then reset.
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 20'h60 + AW'(k), DW'(k), 1, 1, 20'h70 + AW'(k), '0);
            @(negedge clk);
            check("fill_r1_loses", 64'(r1_ready), 64'(0));
            step();
        end
        drive(1, 1, 20'h40, 32'h1, 1, 0, 20'h41, '0);
        @(negedge clk);
        check("prerst_r1_ready", 64'(r1_ready), 64'(1));
        step();
        rst_in = 1'b1;
        drive(1, 1, 20'h50, 32'h2, 1, 1, 20'h51, 32'h3);
        @(negedge clk);
        check("midrst_r1_rvalid", 64'(r1_rvalid), 64'(0));
        check("midrst_r0_ready", 64'(r0_ready), 64'(0));
        check("midrst_r1_ready", 64'(r1_ready), 64'(0));
        check("midrst_write_en", 64'(mem_write_en), 64'(0));
        step();
        rst_in = 1'b0;
        @(negedge clk);
        check("postrst_r0_wins", 64'(r0_ready), 64'(1));
        check("postrst_r1_loses", 64'(r1_ready), 64'(0));
        step();

        // Single requester streams eight reads with no gaps.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(1, 0, AW'(i), '0, 0, 0, '0, '0);
            else       idle();
            @(negedge clk);
            if (i < 8) check("stream_ready", 64'(r0_ready), 64'(1));
            if (i > 0) begin
                check("stream_rvalid", 64'(r0_rvalid), 64'(1));
                check("stream_rdata", 64'(r0_rdata), 64'(32'hA000_0000 + 32'(i - 1)));
            end
            step();
        end

        // Random traffic on a small address range to provoke conflicts and hazards.
        for (int n = 0; n < 3000; n++) begin
            rst_in = ($urandom_range(63) == 0);
            drive($urandom_range(3) != 0, 1'($urandom), AW'($urandom_range(15)), DW'($urandom),
                  $urandom_range(3) != 0, 1'($urandom), AW'($urandom_range(15)), DW'($urandom));
            step();
        end
        rst_in = 1'b0;
        idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
